// File: rtl/pnt_cfg_host.sv
// pnt_cfg_host
//   Host-side initiator for the point-size configuration register port.
//   It takes one read or write command at a time, drives the register's
//   wen/ren/wdata handshake, waits for cfg_ready (with a timeout), decodes
//   the 11-bit point count back into a 3-bit code and returns a one-cycle
//   response.
//
//   Optional feature (define CFG_VERIFY_EN): every write is followed by an
//   automatic readback, and the write response reports the decoded readback.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/ready   command handshake (ready only in IDLE)
//   req_write         1 = write, 0 = read
//   req_code          code to write (points = 8 << code)
//   resp_valid        one-cycle response strobe, no backpressure
//   resp_code         written code or decoded read code
//   resp_points       8 << resp_code, 0 on error or timeout
//   resp_err          readback not a legal one-hot point count
//   resp_timeout      cfg_ready not seen within TIMEOUT_CYCLES
//   cfg_wdata/wen/ren register write data / write enable / read enable
//   cfg_rdata/ready   register read data / ready
module pnt_cfg_host #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int TO_W           = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_code,
  output logic        resp_valid,
  output logic [2:0]  resp_code,
  output logic [10:0] resp_points,
  output logic        resp_err,
  output logic        resp_timeout,
  output logic [2:0]  cfg_wdata,
  output logic        cfg_wen,
  output logic        cfg_ren,
  input  logic [10:0] cfg_rdata,
  input  logic        cfg_ready
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  state_t          state, state_nxt;
  logic            wr_q;
  logic [2:0]      code_q;
  logic [10:0]     rdata_q;
  logic            to_q;
  logic [TO_W-1:0] cnt_q;
  logic            to_hit;
  logic            dec_ok;
  logic [2:0]      dec_code;

  assign to_hit = (cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  // Legal read data is exactly 8 << c for c in 0..7 (one bit in [10:3]).
  always_comb begin
    dec_ok   = 1'b0;
    dec_code = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (rdata_q == (11'd8 << i)) begin
        dec_ok   = 1'b1;
        dec_code = 3'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (req_valid) state_nxt = req_write ? WRITE : READ;
`ifdef CFG_VERIFY_EN
      WRITE: state_nxt = READ;
`else
      WRITE: state_nxt = RESP;
`endif
      READ:  if (cfg_ready || to_hit) state_nxt = RESP;
      RESP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Command latch, read capture and timeout counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= 1'b0;
      code_q  <= 3'd0;
      rdata_q <= 11'd0;
      to_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        wr_q    <= req_write;
        code_q  <= req_code;
        rdata_q <= 11'd0;
        to_q    <= 1'b0;
      end
      if (state_nxt == READ && state != READ) cnt_q <= '0;
      else if (state == READ)                 cnt_q <= cnt_q + TO_W'(1);
      // ready wins over a timeout landing in the same cycle
      if (state == READ) begin
        if (cfg_ready)   rdata_q <= cfg_rdata;
        else if (to_hit) to_q    <= 1'b1;
      end
    end
  end

  assign req_ready = (state == IDLE);
  assign cfg_wen   = (state == WRITE);
  assign cfg_wdata = (state == WRITE) ? code_q : 3'd0;
  assign cfg_ren   = (state == READ);
  assign resp_valid = (state == RESP);

  always_comb begin
    resp_code    = 3'd0;
    resp_points  = 11'd0;
    resp_err     = 1'b0;
    resp_timeout = 1'b0;
    if (state == RESP) begin
      if (to_q) begin
        resp_timeout = 1'b1;
      end else if (wr_q) begin
`ifdef CFG_VERIFY_EN
        resp_err    = !dec_ok || (dec_code != code_q);
        resp_code   = dec_ok ? dec_code : 3'd0;
        resp_points = resp_err ? 11'd0 : rdata_q;
`else
        resp_code   = code_q;
        resp_points = 11'd8 << code_q;
`endif
      end else begin
        resp_err    = !dec_ok;
        resp_code   = dec_ok ? dec_code : 3'd0;
        resp_points = dec_ok ? rdata_q : 11'd0;
      end
    end
  end

endmodule

// File: tb/tb_pnt_cfg_host.sv
// tb_pnt_cfg_host
//   Self-checking bench for pnt_cfg_host. A small register model answers
//   the cfg port (normal, forced read data, never ready, or storing 8 on
//   every write); a command-level model predicts latency, enable pulses and
//   response fields from the point-count rules.
module tb_pnt_cfg_host;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_code = 3'd0;
  logic        resp_valid;
  logic [2:0]  resp_code;
  logic [10:0] resp_points;
  logic        resp_err;
  logic        resp_timeout;
  logic [2:0]  cfg_wdata;
  logic        cfg_wen;
  logic        cfg_ren;
  logic [10:0] cfg_rdata;
  logic        cfg_ready;

  always #5 clk = ~clk;

  pnt_cfg_host #(.TIMEOUT_CYCLES(15), .TO_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_code(req_code),
    .resp_valid(resp_valid), .resp_code(resp_code),
    .resp_points(resp_points), .resp_err(resp_err),
    .resp_timeout(resp_timeout),
    .cfg_wdata(cfg_wdata), .cfg_wen(cfg_wen), .cfg_ren(cfg_ren),
    .cfg_rdata(cfg_rdata), .cfg_ready(cfg_ready)
  );

  // Register model. mode: 0 normal, 1 forced rdata, 2 never ready, 3 stores 8.
  int          mode = 0;
  logic [10:0] force_val = 11'd0;
  logic [10:0] reg_q;
  logic        rdy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_q <= 11'd8;
      rdy_q <= 1'b0;
    end else begin
      rdy_q <= cfg_ren && !cfg_wen && (mode != 2);
      if (cfg_wen) reg_q <= (mode == 3) ? 11'd8 : (11'd8 << cfg_wdata);
    end
  end
  assign cfg_ready = rdy_q;
  assign cfg_rdata = (mode == 1) ? force_val : reg_q;

  int checks = 0;
  int errors = 0;
  int nresp = 0;
  int exp_nresp = 0;
  int stored = 8;   // point count the register holds, tracked at command level

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void decode(input int v, output bit ok, output int c);
    ok = 1'b0;
    c  = 0;
    for (int i = 0; i < 8; i++)
      if (v == 8 * (2 ** i)) begin ok = 1'b1; c = i; end
  endfunction

  // Continuous protocol checks.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("wen_ren_overlap", {31'd0, cfg_wen && cfg_ren}, 0);
      if (resp_valid) nresp <= nresp + 1;
      else chk("resp_fields_idle", {15'd0, resp_code, resp_points, resp_err, resp_timeout}, 0);
    end
  end

  // Issue one command and check it end to end. hold leaves req_valid high.
  task automatic cmd(input bit wr, input int code, input bit hold);
    int k, rens, wens, lat, e_ren, e_code, e_pts, v, dc;
    bit seen, e_err, e_to, ok;
    logic [2:0] wd;
    k = 0;
    @(negedge clk);
    while (!req_ready && k < 50) begin @(negedge clk); k++; end
    chk("wait_req_ready", {31'd0, req_ready}, 1);
    req_valid = 1'b1;
    req_write = wr;
    req_code  = 3'(code);
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
    rens = 0; wens = 0; seen = 0; wd = 3'd0; lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      rens += int'(cfg_ren);
      if (cfg_wen) begin wens++; wd = cfg_wdata; end
      if (resp_valid) begin seen = 1'b1; lat = c; break; end
    end
    // expected behaviour
    e_err = 0; e_to = 0; e_code = 0; e_pts = 0; e_ren = 0;
    if (wr) stored = (mode == 3) ? 8 : 8 * (2 ** code);
    if (wr) begin
`ifdef CFG_VERIFY_EN
      if (mode == 2) begin
        lat = lat; e_to = 1; e_ren = 15;
        chk("lat_wr_verify_to", lat, 17);
      end else begin
        v = (mode == 1) ? int'(force_val) : stored;
        decode(v, ok, dc);
        e_err  = !ok || (dc != code);
        e_code = ok ? dc : 0;
        e_pts  = e_err ? 0 : v;
        e_ren  = 2;
        chk("lat_wr_verify", lat, 4);
      end
`else
      e_code = code;
      e_pts  = 8 * (2 ** code);
      chk("lat_wr", lat, 2);
`endif
      chk("wdata", {29'd0, wd}, code);
    end else if (mode == 2) begin
      e_to = 1; e_ren = 15;
      chk("lat_rd_to", lat, 16);
    end else begin
      v = (mode == 1) ? int'(force_val) : stored;
      decode(v, ok, dc);
      e_err  = !ok;
      e_code = ok ? dc : 0;
      e_pts  = ok ? v : 0;
      e_ren  = 2;
      chk("lat_rd", lat, 3);
    end
    chk("resp_seen", {31'd0, seen}, 1);
    chk("wen_cycles", wens, wr ? 1 : 0);
    chk("ren_cycles", rens, e_ren);
    chk("resp_code", {29'd0, resp_code}, e_code);
    chk("resp_points", {21'd0, resp_points}, e_pts);
    chk("resp_err", {31'd0, resp_err}, {31'd0, e_err});
    chk("resp_timeout", {31'd0, resp_timeout}, {31'd0, e_to});
    chk("busy_not_ready", {31'd0, req_ready}, 0);
    exp_nresp++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    #12;
    chk("rst_req_ready", {31'd0, req_ready}, 1);
    chk("rst_outputs", {26'd0, cfg_wen, cfg_ren, cfg_wdata, resp_valid}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // read of reset value, write 5 then read back
    cmd(0, 0, 0);
    cmd(1, 5, 0);
    cmd(0, 0, 0);
    // illegal read data
    mode = 1; force_val = 11'h018;
    cmd(0, 0, 0);
    // never ready -> timeout, then host is idle again
    mode = 2;
    cmd(0, 0, 0);
    @(negedge clk);
    chk("ready_after_to", {31'd0, req_ready}, 1);
    // back-to-back: write 7 held valid, then read
    mode = 0;
    cmd(1, 7, 1);
    cmd(0, 0, 0);

    // reset in the middle of a read
    mode = 2;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_code = 3'd0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("ren_before_rst", {31'd0, cfg_ren}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ren_in_rst", {30'd0, cfg_ren, cfg_wen}, 0);
    chk("resp_in_rst", {31'd0, resp_valid}, 0);
    stored = 8;
    @(negedge clk);
    rst_n = 1'b1;
    mode = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst", {30'd0, req_ready, resp_valid}, 2);
    end

`ifdef CFG_VERIFY_EN
    cmd(1, 3, 0);
    mode = 3;
    cmd(1, 3, 0);
    mode = 0;
`endif

    // randomized commands
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 5)      mode = 0;
      else if (r == 6) begin
        mode = 1;
        if ($urandom_range(0, 1) == 1) force_val = 11'd8 << $urandom_range(0, 7);
        else force_val = 11'($urandom_range(0, 2047));
      end
      else if (r == 7) mode = 2;
      else             mode = 3;
      cmd(bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 0);
    end

    repeat (3) @(negedge clk);
    chk("resp_count", nresp, exp_nresp);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pnt_cfg_host.md
Name: pnt_cfg_host

Overview:
- Host-side initiator for the point-size configuration register port, i.e. the other end of the cfg wen/ren/ready handshake.
- Accepts one-at-a-time read/write commands from the control sequencer and drives cfg_wen/cfg_ren/cfg_wdata.
- Waits for cfg_ready, decodes the 11-bit point count back to a 3-bit code, and returns a single-cycle response with error and timeout flags.

Parameters:
- TIMEOUT_CYCLES, 15: maximum number of cycles cfg_ren stays high without cfg_ready before the read is aborted (1..255).
- TO_W, 8: width of the timeout counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  command valid
- req_ready  out  1  host can accept a command (high only in IDLE)
- req_write  in  1  1 = write, 0 = read
- req_code  in  3  point-size code to write (N = 8 << code)
- resp_valid  out  1  one-cycle response strobe; no backpressure
- resp_code  out  3  written code, or decoded read code
- resp_points  out  11  8 << resp_code; 0 on error or timeout
- resp_err  out  1  read data not a legal one-hot value in bits [10:3]
- resp_timeout  out  1  cfg_ready not seen within TIMEOUT_CYCLES
- cfg_wdata  out  3  to register write data
- cfg_wen  out  1  to register write enable
- cfg_ren  out  1  to register read enable
- cfg_rdata  in  11  from register read data
- cfg_ready  in  1  from register; high the cycle after ren is sampled while wen is low

Behaviour:
- Reset: rst_n is asynchronous and active-low; clk is the clock. All registered outputs are 0 and the state is IDLE.
- req_ready is combinational from the state: 1 in IDLE, including immediately after reset.
- States: IDLE, WRITE, READ, RESP.
- IDLE:
  - Accept occurs when req_valid && req_ready at a rising edge.
  - Latch req_write and req_code.
  - Go to WRITE if write, else READ.
- WRITE:
  - cfg_wen = 1 and cfg_wdata = latched code for exactly one cycle.
  - Next state is RESP, or READ when CFG_VERIFY_EN is defined.
- READ:
  - cfg_ren = 1 continuously and cfg_wen = 0; the timeout counter clears on entry and increments each cycle.
  - If cfg_ready is sampled 1: capture cfg_rdata, drop cfg_ren, go to RESP.
  - Else if count == TIMEOUT_CYCLES-1: drop cfg_ren, set the timeout flag, go to RESP.
  - cfg_ready has priority over timeout when both occur in the same cycle.
- RESP:
  - Drive resp_valid = 1 for one cycle with the response fields, then return to IDLE.
  - All resp_* fields return to 0 when resp_valid is 0.
- Read decode:
  - cfg_rdata with exactly one bit set in [10:3] and bits [2:0] = 0 gives resp_code = bit index − 3 and resp_points = cfg_rdata.
  - Any other value (including 0) gives resp_err = 1, resp_code = 0, resp_points = 0.
- Write response: resp_code = latched code, resp_points = 8 << code, resp_err = 0.
- Latency, with accept at edge E:
  - Write: cfg_wen high in cycle E+1; resp_valid in cycle E+2.
  - Read against a conformant register: cfg_ren high in cycles E+1..E+2, cfg_ready high in E+2, resp_valid in E+3.
- cfg_wen and cfg_ren are never high in the same cycle. cfg_ren is low in RESP, so the register's ready falls before the next command.
- req_valid while not IDLE is ignored; the command is not queued.
- cfg_ready high outside READ is ignored.
- Reset asserted mid-transaction: all outputs drop to 0 asynchronously and no response is issued for the aborted command.
- Arithmetic: resp_points is formed as 11'd8 << code, 11 bits, no overflow for codes 0..7.

Optional Feature:
- Macro: CFG_VERIFY_EN
- Defined:
  - Every write is followed by an automatic readback (WRITE -> READ -> RESP).
  - The write response reports the decoded readback.
  - resp_err = 1 if the decoded code differs from the written code or the readback value is illegal.
  - resp_timeout applies to the readback.
  - Write latency becomes resp_valid at E+4.
- Undefined: writes complete without readback and resp_valid is at E+2; the readback logic is removed.

Test Plan:
- Reset, then a read with the register at its reset value 8 -> cfg_ren high for 2 cycles; resp_valid at E+3 with resp_code 0, resp_points 8, resp_err 0.
- Write code 5, then read -> cfg_wen one cycle with cfg_wdata 5; write resp_points 256; read resp_code 5, resp_points 256.
- Read with the register model forcing cfg_rdata = 11'h018 -> resp_err 1, resp_code 0, resp_points 0.
- Read with cfg_ready held 0 -> cfg_ren high exactly 15 cycles; resp_timeout 1, resp_points 0; req_ready returns to 1 afterwards.
- req_valid held high back-to-back (write code 7, then read) -> second command accepted only after resp_valid; read returns 1024; cfg_wen and cfg_ren never overlap.
- rst_n asserted during READ -> cfg_ren 0 immediately, no resp_valid, req_ready 1 after release.
- With CFG_VERIFY_EN: write code 3 to a good model -> resp at E+4, points 64, err 0. Write code 3 to a model that stores 8 -> resp_err 1.
